// File: rtl/imm_enc_pkg.sv
// Shared types, instruction field positions and range helper for the RV32 immediate encoder.
package imm_enc_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

    typedef struct packed {
        imm_src_e    src;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } imm_req_t;

    // True when every bit from nbits-1 upward equals the sign bit.
    function automatic logic fits_signed(input logic [31:0] value, input int nbits);
        logic [31:0] shifted;
        shifted = $signed(value) >>> (nbits - 1);
        return (shifted == 32'h0000_0000) || (shifted == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer and range/alignment checker: one registered request in, one RV32 word out.
module imm_pack
    import imm_enc_pkg::*;
(
    input  imm_req_t    req_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    // Out-of-range requests still get packed from the truncated fields.
    always_comb begin
        instr_o = 32'h0000_0000;
        err_o   = 1'b0;
        instr_o[OPC_LSB +: 7] = req_i.opcode;
        case (req_i.src)
            IMM_I: begin
                instr_o[31:20]          = req_i.imm[11:0];
                instr_o[RS1_LSB +: 5]   = req_i.rs1;
                instr_o[F3_LSB +: 3]    = req_i.funct3;
                instr_o[RD_LSB +: 5]    = req_i.rd;
                err_o                   = !fits_signed(req_i.imm, 12);
            end
            IMM_S: begin
                instr_o[31:25]          = req_i.imm[11:5];
                instr_o[RS2_LSB +: 5]   = req_i.rs2;
                instr_o[RS1_LSB +: 5]   = req_i.rs1;
                instr_o[F3_LSB +: 3]    = req_i.funct3;
                instr_o[11:7]           = req_i.imm[4:0];
                err_o                   = !fits_signed(req_i.imm, 12);
            end
            IMM_B: begin
                instr_o[31]             = req_i.imm[12];
                instr_o[30:25]          = req_i.imm[10:5];
                instr_o[RS2_LSB +: 5]   = req_i.rs2;
                instr_o[RS1_LSB +: 5]   = req_i.rs1;
                instr_o[F3_LSB +: 3]    = req_i.funct3;
                instr_o[11:8]           = req_i.imm[4:1];
                instr_o[7]              = req_i.imm[11];
                err_o                   = !fits_signed(req_i.imm, 13) || req_i.imm[0];
            end
            IMM_J: begin
                instr_o[31]             = req_i.imm[20];
                instr_o[30:21]          = req_i.imm[10:1];
                instr_o[20]             = req_i.imm[11];
                instr_o[19:12]          = req_i.imm[19:12];
                instr_o[RD_LSB +: 5]    = req_i.rd;
                err_o                   = !fits_signed(req_i.imm, 21) || req_i.imm[0];
            end
            default: begin
                instr_o = 32'h0000_0000;
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready RV32 immediate encoder (S1 raw request, S2 packed word).
// Optional saturating error counter enabled by defining IMM_ENC_ERR_CNT_EN.
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_imm_src,
    input  logic [31:0]          in_imm,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_imm_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic        s1_v_q, s1_v_d;
    imm_req_t    s1_req_q, s1_req_d;
    logic        s2_v_q, s2_v_d;
    logic [31:0] s2_instr_q, s2_instr_d;
    logic        s2_err_q, s2_err_d;
    logic        s2_take_s, s1_take_s;
    logic [31:0] pack_instr_s;
    logic        pack_err_s;

    assign s2_take_s = !s2_v_q || out_ready;
    assign s1_take_s = !s1_v_q || s2_take_s;
    assign in_ready  = s1_take_s;

    imm_pack u_pack (
        .req_i   (s1_req_q),
        .instr_o (pack_instr_s),
        .err_o   (pack_err_s)
    );

    // Each stage reloads only when it is empty or its content leaves this cycle.
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_req_d   = s1_req_q;
        s2_v_d     = s2_v_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        if (s1_take_s) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_req_d = '{src: imm_src_e'(in_imm_src), imm: in_imm, opcode: in_opcode,
                             rd: in_rd, funct3: in_funct3, rs1: in_rs1, rs2: in_rs2};
            end else begin
                s1_req_d = s1_req_q;
            end
        end else begin
            s1_v_d = s1_v_q;
        end
        if (s2_take_s) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_instr_d = pack_instr_s;
                s2_err_d   = pack_err_s;
            end else begin
                s2_instr_d = s2_instr_q;
                s2_err_d   = s2_err_q;
            end
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v_q     <= 1'b0;
            s1_req_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_instr_q <= 32'h0000_0000;
            s2_err_q   <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_req_q   <= s1_req_d;
            s2_v_q     <= s2_v_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid   = s2_v_q;
    assign out_instr   = s2_instr_q;
    assign out_imm_err = s2_err_q;

`ifdef IMM_ENC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts delivered erroring words, sticking at all-ones.
    always_comb begin
        if (out_valid && out_ready && s2_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_cnt_q <= {ERR_CNT_W{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized self-checking bench for imm_encoder with an arithmetic reference model and scoreboard.
module tb_imm_encoder;

`ifdef IMM_ENC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_imm_src;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_imm_err;
    logic [15:0] err_count;

    imm_encoder #(.ERR_CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_src(in_imm_src), .in_imm(in_imm), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_imm_err(out_imm_err), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        next_exp;
    int unsigned cnt_model = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          bvals [16] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                                4096, -1048576, 1048574, 1048576, -1048578, 1, 0, -1};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: fields placed with shifts and masks, range judged on the integer value.
    function automatic exp_t model(input logic [1:0] src, input logic [31:0] u, input logic [6:0] opc,
                                   input logic [4:0] rd, input logic [2:0] f3,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t r;
        int   s;
        s = $signed(u);
        case (src)
            2'd0: begin
                r.instr = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
                r.err   = (s < -2048) || (s > 2047);
            end
            2'd1: begin
                r.instr = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                          (32'(f3) << 12) | ((u & 32'h1F) << 7) | 32'(opc);
                r.err   = (s < -2048) || (s > 2047);
            end
            2'd2: begin
                r.instr = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
                          (32'(rs1) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hF) << 8) |
                          (((u >> 11) & 32'h1) << 7) | 32'(opc);
                r.err   = (s < -4096) || (s > 4095) || ((u & 32'h1) != 32'h0);
            end
            default: begin
                r.instr = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                          (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) |
                          (32'(rd) << 7) | 32'(opc);
                r.err   = (s < -1048576) || (s > 1048575) || ((u & 32'h1) != 32'h0);
            end
        endcase
        return r;
    endfunction

    task automatic set_req(input logic [1:0] src, input logic [31:0] imm, input logic [6:0] opc,
                           input logic [4:0] rd, input logic [2:0] f3,
                           input logic [4:0] rs1, input logic [4:0] rs2);
        in_imm_src = src; in_imm = imm; in_opcode = opc; in_rd = rd;
        in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1;
    endtask

    task automatic set_rand_req();
        logic [31:0] imm;
        case ($urandom_range(0, 2))
            0:       imm = $urandom();
            1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            default: imm = bvals[$urandom_range(0, 15)];
        endcase
        set_req(2'($urandom_range(0, 3)), imm, 7'($urandom()), 5'($urandom()), 3'($urandom()),
                5'($urandom()), 5'($urandom()));
        next_exp = model(in_imm_src, in_imm, in_opcode, in_rd, in_funct3, in_rs1, in_rs2);
    endtask

    // One clock: score the output transfer, record the input transfer, then advance.
    task automatic step(output bit accepted);
        exp_t e;
        #1;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                check_eq("instr", out_instr, e.instr);
                check_eq("imm_err", {31'd0, out_imm_err}, {31'd0, e.err});
                if (e.err && cnt_model != 32'hFFFF) cnt_model++;
            end
        end
        if (accepted) q.push_back(next_exp);
        @(posedge clock);
        #1;
        check_eq("err_count", 32'(err_count), CNT_EN ? cnt_model : 32'd0);
    endtask

    task automatic drain(input string tag);
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12 && q.size() != 0; k++) step(acc);
        check_eq(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        bit c_sent;
        reset = 1'b1; out_ready = 1'b0;
        set_req(2'd0, 32'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_imm_err", {31'd0, out_imm_err}, 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Two-cycle latency on the reference I-type word.
        out_ready = 1'b1;
        set_req(2'd0, 32'hFFFF_FFFF, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0);
        next_exp = '{instr: 32'hFFF0_0093, err: 1'b0};
        step(acc);
        check_eq("t1_accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        check_eq("t1_valid_c1", {31'd0, out_valid}, 32'd0);
        step(acc);
        check_eq("t1_valid_c2", {31'd0, out_valid}, 32'd1);
        check_eq("t1_instr", out_instr, 32'hFFF0_0093);
        drain("t1_drain");

        // Directed S/B/J words plus two range errors, back to back.
        set_req(2'd1, 32'd8, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2);
        next_exp = '{instr: 32'h0020_A423, err: 1'b0}; step(acc);
        set_req(2'd2, 32'hFFFF_FFFC, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0);
        next_exp = '{instr: 32'hFE00_0EE3, err: 1'b0}; step(acc);
        set_req(2'd3, 32'h0000_0800, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0);
        next_exp = '{instr: 32'h0010_00EF, err: 1'b0}; step(acc);
        set_req(2'd2, 32'd5, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0);
        next_exp = '{instr: 32'h0000_0263, err: 1'b1}; step(acc);
        set_req(2'd0, 32'd2048, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0);
        next_exp = '{instr: 32'h8000_0013, err: 1'b1}; step(acc);
        drain("t3_drain");
        check_eq("t3_err_count", 32'(err_count), CNT_EN ? 32'd2 : 32'd0);

        // Backpressure: two buffered, third stalls, output holds.
        out_ready = 1'b0;
        set_rand_req(); step(acc);
        check_eq("t4_acc_a", {31'd0, acc}, 32'd1);
        set_rand_req(); step(acc);
        check_eq("t4_acc_b", {31'd0, acc}, 32'd1);
        set_rand_req();
        for (int k = 0; k < 4; k++) begin
            check_eq("t4_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("t4_hold_instr", out_instr, q[0].instr);
            step(acc);
        end
        out_ready = 1'b1;
        c_sent = 1'b0;
        for (int k = 0; k < 12 && (q.size() != 0 || in_valid); k++) begin
            step(acc);
            if (acc) begin
                in_valid = 1'b0;
                c_sent = 1'b1;
            end
        end
        check_eq("t4_c_accepted", {31'd0, c_sent}, 32'd1);
        check_eq("t4_drain", 32'(q.size()), 32'd0);

        // Reset with both stages full, then a clean request.
        out_ready = 1'b0;
        set_rand_req(); step(acc);
        set_rand_req(); step(acc);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("t5_valid_rst", {31'd0, out_valid}, 32'd0);
        check_eq("t5_cnt_rst", 32'(err_count), 32'd0);
        q.delete();
        cnt_model = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        set_req(2'd3, 32'hFFF0_0000, 7'h6F, 5'd5, 3'd0, 5'd0, 5'd0);
        next_exp = model(in_imm_src, in_imm, in_opcode, in_rd, in_funct3, in_rs1, in_rs2);
        step(acc);
        check_eq("t5_accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        check_eq("t5_valid_c1", {31'd0, out_valid}, 32'd0);
        step(acc);
        check_eq("t5_valid_c2", {31'd0, out_valid}, 32'd1);
        drain("t5_drain");

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            set_rand_req();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
